// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operation
// codes, datapath mux selects and the decoded opcode/funct values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_SLT   = 3'd3
  } alu_op_e;

  // Register-file write address select
  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  // Register-file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SRC_B_REG      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR     = 2'd1;
  localparam logic [1:0] SRC_B_SEXT     = 2'd2;
  localparam logic [1:0] SRC_B_SEXT_SH2 = 2'd3;

  // Next-PC select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  // Instruction fields
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

endpackage

// File: rtl/mc_wait_timer.sv
// Stall counter for memory-wait states. Counts consecutive stalled cycles,
// clears whenever the controller is not stalling, and flags expiry on the
// TIMEOUT-th consecutive stalled cycle so the FSM can leave that same cycle.
module mc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  // Stall cycle counter; reset and clear both return it to zero.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (stall_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = stall_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM. Drives datapath strobes and mux selects
// from the current state, tracks retired instructions and a sticky fault flag,
// and halts when a memory access stalls for TIMEOUT cycles.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  pc_src_o,
  output logic [2:0]  alu_op_o,
  output logic [3:0]  state_o,
  output logic        error_o,
  output logic [31:0] retired_o
);

  state_e      state_q, state_d;
  logic        error_q, error_d;
  logic [31:0] retired_q, retired_d;
  logic        stall;
  logic        expired;

  // A stall is a memory-wait state whose access has not completed yet.
  assign stall = ((state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR)) && !mem_ready_i;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_i   (stall),
    .clear_i   (!stall),
    .expired_o (expired)
  );

  // State, fault flag and retire counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, control outputs, fault and retire updates from current state.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    error_d      = error_q;
    retired_d    = retired_q;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    reg_dst_o    = REG_DST_RT;
    mem_to_reg_o = M2R_ALUOUT;
    alu_src_b_o  = SRC_B_REG;
    pc_src_o     = PC_SRC_ALU;
    alu_op_o     = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alu_src_b_o = SRC_B_SEXT_SH2;
        case (opcode_i)
          OP_RTYPE:         state_d = (funct_i == FUNCT_JR) ? S_JUMP : S_EXEC_R;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J, OP_JAL:     state_d = S_JUMP;
          default: begin
            error_d = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        reg_dst_o   = REG_DST_RD;
        state_d     = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_SEXT;
        alu_op_o    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d     = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (opcode_i == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
        retired_d   = retired_q + 32'd1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_SEXT;
        state_d     = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) begin
          state_d = S_WB_MEM;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
        retired_d    = retired_q + 32'd1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = PC_SRC_ALUOUT;
        pc_write_o  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
        retired_d   = retired_q + 32'd1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = (opcode_i == OP_RTYPE) ? PC_SRC_RS : PC_SRC_JUMP;
        if (opcode_i == OP_JAL) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = REG_DST_R31;
          mem_to_reg_o = M2R_PC;
        end
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_o   = state_q;
  assign error_o   = error_q;
  assign retired_o = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum wait cycles for mem_ready_i in any memory state.
REQ-002 clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  leave IDLE and begin fetching when high.
REQ-005 opcode_i  in  6  instruction[31:26] from the instruction register.
REQ-006 funct_i  in  6  instruction[5:0] from the instruction register.
REQ-007 zero_i  in  1  ALU zero flag.
REQ-008 mem_ready_i  in  1  memory completes the current access this cycle.
REQ-009 Control outputs, 1 bit each: pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o, alu_src_a_o.
REQ-010 Control outputs, 2 bits each: reg_dst_o (0 rt, 1 rd, 2 r31), mem_to_reg_o (0 ALUOut, 1 MDR, 2 PC), alu_src_b_o (0 B, 1 const 4, 2 sign-ext, 3 sign-ext<<2), pc_src_o (0 ALU, 1 ALUOut, 2 jump target, 3 rs).
REQ-011 alu_op_o  out  3  0 add, 1 sub, 2 decode by funct, 3 slt.
REQ-012 state_o  out  4  current state encoding; error_o out 1, sticky fault flag; retired_o out 32, retired-instruction count.

Function
REQ-013 States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
REQ-014 All control outputs are Moore functions of state, except pc_write_o/ir_write_o in FETCH and pc_write_o in BRANCH; inactive outputs are 0.
REQ-015 IDLE: all strobes 0; start_i=1 -> FETCH.
REQ-016 FETCH: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op add, pc_src_o=0; wait while mem_ready_i=0; on mem_ready_i=1 assert ir_write_o=1 and pc_write_o=1 that cycle -> DECODE.
REQ-017 DECODE, one cycle: alu_src_a_o=0, alu_src_b_o=3, alu_op add (branch target into ALUOut); next state by opcode.
REQ-018 Opcode 000000: funct 001000 (jr) -> JUMP with pc_src_o=3; otherwise -> EXEC_R.
REQ-019 Opcodes 001000 addi, 001010 slti -> EXEC_I; 100011 lw, 101011 sw -> MEM_ADDR; 000100 beq, 000101 bne -> BRANCH; 000010 j, 000011 jal -> JUMP.
REQ-020 Any other opcode: error_o set, -> FETCH, retired_o unchanged.
REQ-021 EXEC_R: alu_src_a_o=1, alu_src_b_o=0, alu_op 2 -> WB_ALU with reg_dst_o=1.
REQ-022 EXEC_I: alu_src_a_o=1, alu_src_b_o=2, alu_op add (addi) or slt (slti) -> WB_ALU with reg_dst_o=0.
REQ-023 WB_ALU: reg_write_o=1, mem_to_reg_o=0, one cycle -> FETCH.
REQ-024 MEM_ADDR: alu_src_a_o=1, alu_src_b_o=2, alu_op add -> MEM_RD (lw) or MEM_WR (sw).
REQ-025 MEM_RD: mem_read_o=1, iord_o=1; hold until mem_ready_i -> WB_MEM. MEM_WR: mem_write_o=1, iord_o=1; hold until mem_ready_i -> FETCH.
REQ-026 WB_MEM: reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0 -> FETCH.
REQ-027 BRANCH: alu_src_a_o=1, alu_src_b_o=0, alu_op sub, pc_src_o=1; pc_write_o = zero_i for beq, ~zero_i for bne; -> FETCH.
REQ-028 JUMP: pc_write_o=1; pc_src_o=2 for j/jal, 3 for jr; jal additionally reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2; -> FETCH.
REQ-029 Wait counter increments each stalled cycle in FETCH/MEM_RD/MEM_WR, clears on state change; reaching TIMEOUT sets error_o -> HALT.
REQ-030 HALT: all strobes 0; exits only via reset.
REQ-031 retired_o increments by 1 on the final cycle of every legal instruction (WB_ALU, WB_MEM, MEM_WR completion, BRANCH, JUMP); wraps 0xFFFFFFFF -> 0.
REQ-032 mem_read_o and mem_write_o are never high together; start_i is ignored outside IDLE.

Reset
REQ-033 rst_i=0 asynchronously forces IDLE, all outputs 0, wait counter 0, retired_o 0, error_o 0, including mid memory access.

Structure
REQ-034 State encodings, alu_op codes, mux select codes and opcode/funct constants live in shared package mc_pkg.
REQ-035 One sub-module, mc_wait_timer: TIMEOUT-parameterised stall counter with clear and expiry outputs.

Verification
REQ-036 Reset, start_i=1, FETCH with mem_ready_i=1, opcode 000000 funct 100000 -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_write_o=1, reg_dst_o=1; retired_o=1.
REQ-037 lw with mem_ready_i low 3 cycles in MEM_RD -> mem_read_o held 4 cycles, then WB_MEM, mem_to_reg_o=1; 5 states plus 3 stalls.
REQ-038 beq zero_i=1 -> pc_write_o=1, pc_src_o=1; bne zero_i=1 -> pc_write_o=0; both retire.
REQ-039 jal -> JUMP: pc_write_o=1, pc_src_o=2, reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2; jr (000000/001000) -> pc_src_o=3, reg_write_o=0.
REQ-040 mem_ready_i held 0 in FETCH for 16 cycles -> error_o=1, HALT; opcode 111111 -> error_o=1, back to FETCH, retired_o unchanged.
REQ-041 rst_i low during MEM_WR -> mem_write_o drops immediately, state_o=IDLE, retired_o=0.
